matrix_writer: RTL and testbench
================================

MATRIX_WRITER -- requirements
Module: matrix_writer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the element and memory data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the memory address width (16 entries).
REQ-003 The block SHALL have parameter N_ELEM, default 9, meaning the elements per matrix (3x3, row-major).
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, a synchronous, active-low reset sampled on the rising edge of clock.
REQ-006 The block SHALL have port Start, input, 1, a request to begin loading one matrix.
REQ-007 The block SHALL have port start_adress, input, ADDR_W, the memory base address of the first element.
REQ-008 The block SHALL have port in_data, input, DATA_W, the incoming matrix element.
REQ-009 The block SHALL have port in_valid, input, 1, qualifying in_data.
REQ-010 The block SHALL have port in_ready, output, 1, set when the block accepts an element this cycle.
REQ-011 The block SHALL have port wr_en, output, 1, the memory write strobe.
REQ-012 The block SHALL have port adress, output, ADDR_W, the memory write address.
REQ-013 The block SHALL have port data_out, output, DATA_W, the memory write data.
REQ-014 The block SHALL have port busy, output, 1, high while a matrix load is in progress.
REQ-015 The block SHALL have port Done, output, 1, a one-cycle pulse when the last element is written.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD and FINISH.
REQ-017 In IDLE with Start=1, the FSM SHALL latch start_adress into the write pointer, clear the element counter and go to LOAD.
REQ-018 in_ready SHALL equal 1 exactly when the state is LOAD; it is combinational from state only, with no dependence on in_valid.
REQ-019 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-020 An accepted beat SHALL produce a registered write in the next cycle: wr_en=1, adress=pointer, data_out=in_data; outside such cycles wr_en=0 and adress/data_out hold their last values.
REQ-021 After each accepted beat, the pointer SHALL increment modulo 2^ADDR_W, so 15 wraps to 0.
REQ-022 When the N_ELEM-th beat is accepted, the FSM SHALL go to FINISH; Done=1 SHALL coincide with that last write cycle.
REQ-023 FINISH SHALL last exactly one cycle, then return to IDLE; Start in FINISH is ignored.
REQ-024 Start SHALL be ignored while busy (LOAD or FINISH); busy=1 in LOAD and FINISH.
REQ-025 in_valid gaps SHALL stall progress indefinitely without a timeout; the counter is unchanged during gaps.

Reset
REQ-026 With reset=0 at a rising edge, the block SHALL set state=IDLE, pointer=0, counter=0, wr_en=0, adress=0, data_out=0, Done=0 and busy=0.
REQ-027 Reset mid-load SHALL abort the load: no further writes are issued, the pending registered write is dropped and no Done is generated.

Configuration
REQ-028 With macro MATRIX_WRITER_CHECKSUM_EN defined, the block SHALL add output port checksum (DATA_W), the modulo-2^DATA_W sum of the accepted elements.
REQ-029 The checksum SHALL be cleared on Start acceptance and on reset, become valid in the Done cycle, and be held until the next Start.
REQ-030 Without MATRIX_WRITER_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Case 1 SHALL check reset=0 for 2 cycles: all outputs are 0 and in_ready=0.
REQ-032 Case 2 SHALL check start_adress=1, Start pulse, bytes 1..9 back-to-back: writes to addresses 1..9 with data 1..9 on consecutive cycles, and Done=1 with the write to address 9.
REQ-033 Case 3 SHALL check start_adress=12, 9 bytes: addresses 12,13,14,15,0,1,2,3,4.
REQ-034 Case 4 SHALL check in_valid low 3 cycles between beats 4 and 5, plus Start pulsed mid-load: no extra writes, exactly 9 writes, and 1 Done.
REQ-035 Case 5 SHALL check reset=0 after beat 5: no write for beat 6 onward and no Done; then Start with start_adress=0 gives a clean 9-write load.
REQ-036 Case 6 (MATRIX_WRITER_CHECKSUM_EN) SHALL check bytes 0x80,0x80,1,1,1,1,1,1,1: checksum=0x07 at Done.

Source files
------------

// File: rtl/matrix_writer.sv
// Loads one 3x3 matrix from a valid-qualified element stream into memory,
// starting at a latched base address. Optional checksum: MATRIX_WRITER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | waiting for Start; base address and counter are latched on Start
// LOAD   | accepting elements (in_ready=1); each beat becomes a write next cycle
// FINISH | single cycle carrying the last write and Done, then back to IDLE
module matrix_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int N_ELEM = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] start_adress,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] adress,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              Done
`ifdef MATRIX_WRITER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int CNT_W = $clog2(N_ELEM + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  cnt;
  logic              start_ok;
  logic              accept;
  logic              last_beat;

  assign last_beat = (cnt == CNT_W'(N_ELEM - 1));

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    start_ok  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          start_ok  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        if (in_valid && last_beat) state_nxt = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write port is registered one cycle behind acceptance; Done rides with the last write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr      <= '0;
      cnt      <= '0;
      wr_en    <= 1'b0;
      adress   <= '0;
      data_out <= '0;
      Done     <= 1'b0;
    end else begin
      wr_en <= accept;
      Done  <= accept && last_beat;
      if (start_ok) begin
        ptr <= start_adress;
        cnt <= '0;
      end else if (accept) begin
        ptr      <= ptr + ADDR_W'(1);
        cnt      <= cnt + CNT_W'(1);
        adress   <= ptr;
        data_out <= in_data;
      end
    end
  end

`ifdef MATRIX_WRITER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (!reset)        checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (accept)   checksum <= checksum + in_data;
  end
`endif

endmodule

// File: tb/tb_matrix_writer.sv
// Directed bench for matrix_writer: expected writes are queued as beats are
// driven and compared by a negedge monitor as the DUT issues them.
module tb_matrix_writer;

  logic       clock;
  logic       reset;
  logic       Start;
  logic [3:0] start_adress;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [3:0] adress;
  logic [7:0] data_out;
  logic       busy;
  logic       Done;
`ifdef MATRIX_WRITER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  matrix_writer #(.DATA_W(8), .ADDR_W(4), .N_ELEM(9)) dut (
    .clock        (clock),
    .reset        (reset),
    .Start        (Start),
    .start_adress (start_adress),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .adress       (adress),
    .data_out     (data_out),
    .busy         (busy),
    .Done         (Done)
`ifdef MATRIX_WRITER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         writes = 0;
  int         dones = 0;
  logic [3:0] mptr;
  logic [7:0] msum;
  logic [7:0] pat[9];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (wr_en === 1'b1) begin
      writes++;
      if (Done === 1'b1) dones++;
      if (exp_q.size() == 0) chk("extra_write", {31'd0, wr_en}, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {28'd0, adress}, {28'd0, e.a});
        chk("wr_data", {24'd0, data_out}, {24'd0, e.d});
        chk("wr_done", {31'd0, Done}, {31'd0, e.last});
      end
    end else if (Done === 1'b1) begin
      chk("done_without_write", {31'd0, Done}, 32'd0);
    end
  end

  task automatic beat(input logic [7:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    chk("in_ready_load", {31'd0, in_ready}, 32'd1);
    exp_q.push_back('{a: mptr, d: d, last: last});
    mptr = mptr + 4'd1;
    msum = msum + d;
    cyc();
    in_valid = 1'b0;
  endtask

  // One full load of pat[] at base address a; optional 3-cycle gap after beat
  // gap_at and a stray Start/base change during the load and in FINISH.
  task automatic load(input logic [3:0] a, input int gap_at, input bit noise);
    int w0, d0;
    w0 = writes;
    d0 = dones;
    start_adress = a;
    Start = 1'b1;
    mptr = a;
    msum = 8'd0;
    cyc();
    Start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
`ifdef MATRIX_WRITER_CHECKSUM_EN
    chk("checksum_cleared", {24'd0, checksum}, 32'd0);
`endif
    for (int i = 0; i < 9; i++) begin
      if (noise && i == 2) begin
        Start = 1'b1;
        start_adress = 4'd7;
      end
      beat(pat[i], i == 8);
      Start = 1'b0;
      if (i + 1 == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          in_data = 8'hEE;
          cyc();
          chk("in_ready_gap", {31'd0, in_ready}, 32'd1);
        end
      end
    end
    chk("busy_finish", {31'd0, busy}, 32'd1);
    chk("in_ready_finish", {31'd0, in_ready}, 32'd0);
`ifdef MATRIX_WRITER_CHECKSUM_EN
    chk("checksum_done", {24'd0, checksum}, {24'd0, msum});
`endif
    if (noise) Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk("busy_idle", {31'd0, busy}, 32'd0);
    cyc();
    chk("busy_idle2", {31'd0, busy}, 32'd0);
`ifdef MATRIX_WRITER_CHECKSUM_EN
    chk("checksum_held", {24'd0, checksum}, {24'd0, msum});
`endif
    chk("write_count", writes - w0, 32'd9);
    chk("done_count", dones - d0, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    Start = 1'b0;
    start_adress = 4'd0;
    in_data = 8'd0;
    in_valid = 1'b0;

    // Case 1: reset held two cycles
    cyc();
    cyc();
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_adress", {28'd0, adress}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef MATRIX_WRITER_CHECKSUM_EN
    chk("rst_checksum", {24'd0, checksum}, 32'd0);
`endif
    reset = 1'b1;
    cyc();

    // Case 2: base 1, data 1..9 back-to-back
    for (int i = 0; i < 9; i++) pat[i] = 8'(i + 1);
    load(4'd1, 0, 1'b0);

    // Case 3: base 12 wraps through 15 to 0
    for (int i = 0; i < 9; i++) pat[i] = 8'(8'h20 + i);
    load(4'd12, 0, 1'b0);

    // Case 4: gap after beat 4, Start noise mid-load and in FINISH
    for (int i = 0; i < 9; i++) pat[i] = 8'(8'hA0 + 3 * i);
    load(4'd5, 4, 1'b1);

    // Case 5: reset after beat 5 aborts the load
    begin
      int w0, d0;
      start_adress = 4'd3;
      Start = 1'b1;
      mptr = 4'd3;
      msum = 8'd0;
      cyc();
      Start = 1'b0;
      for (int i = 0; i < 5; i++) beat(8'(8'h50 + i), 1'b0);
      w0 = writes + 1;  // beat 5's write is still visible before the reset edge
      d0 = dones;
      reset = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h55;
      cyc();
      chk("abort_wr_en", {31'd0, wr_en}, 32'd0);
      chk("abort_adress", {28'd0, adress}, 32'd0);
      chk("abort_data_out", {24'd0, data_out}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
        in_data = 8'(8'h56 + i);
        cyc();
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      cyc();
      chk("abort_no_writes", writes - w0, 32'd0);
      chk("abort_no_done", dones - d0, 32'd0);
      chk("abort_queue", exp_q.size(), 32'd0);
    end
    for (int i = 0; i < 9; i++) pat[i] = 8'(8'h90 + i);
    load(4'd0, 0, 1'b0);

    // Case 6: checksum wraps modulo 256 to 0x07
    pat[0] = 8'h80;
    pat[1] = 8'h80;
    for (int i = 2; i < 9; i++) pat[i] = 8'h01;
    load(4'd8, 0, 1'b0);
`ifdef MATRIX_WRITER_CHECKSUM_EN
    chk("checksum_case6", {24'd0, checksum}, 32'h07);
`endif

    cyc();
    cyc();
    chk("final_queue", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
